dac_frame_sched: RTL and testbench

Sample-rate scheduler and word formatter that sits directly upstream of the DAC SPI master (`MasterOut`). It buffers signed 12-bit samples from the equalizer output and converts each one to a 16-bit DAC word: 4 leading zeros, then 12 data bits in offset binary. On every sample tick it drives the active-low `start` frame strobe for exactly one serializer transfer, holding `dac_word` stable for the whole frame.

---
 rtl/dac_pkg.sv | 22 ++
 rtl/dac_frame_sched_sample_fifo.sv | 58 +++++
 rtl/dac_frame_sched.sv | 105 ++++++++++
 tb/tb_dac_frame_sched.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants, FSM encoding and sample-to-DAC-word formatting for the DAC path.
// MasterOut integrators reference DAC_FRAME_LEN so frame timing stays in step.
package dac_pkg;

  localparam int DAC_FRAME_LEN = 132;
  localparam int DAC_WORD_W    = 16;
  localparam int DAC_SAMPLE_W  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_GUARD = 2'd2
  } dac_state_e;

  // Two's complement to offset binary, left-padded with four zero bits.
  function automatic logic [DAC_WORD_W-1:0] to_dac_word(input logic signed [DAC_SAMPLE_W-1:0] sample);
    logic [DAC_SAMPLE_W-1:0] ob;
    ob = sample ^ 12'h800;
    return {4'b0000, ob};
  endfunction

endpackage

// File: rtl/dac_frame_sched_sample_fifo.sv
// DEPTH x WIDTH synchronous FIFO with occupancy count; DEPTH must be a power of two.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     ready_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q, level_d;
  logic             push_ok, pop_ok;

  assign ready_o = (level_q != (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop on empty never bypasses a same-cycle push; the push is simply stored.
  assign push_ok = push_i & ready_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dac_frame_sched.sv
// Sample-rate scheduler: buffers samples, pops one per tick and frames it for the DAC serializer.
// state | meaning: IDLE wait for tick (start=1) | FRAME start=0 for FRAME_LEN | GUARD start=1 for GUARD
module dac_frame_sched import dac_pkg::*; #(
  parameter int DIV       = 2272,
  parameter int FRAME_LEN = DAC_FRAME_LEN,
  parameter int GUARD     = 4,
  parameter int DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [DAC_SAMPLE_W-1:0]     sample_in,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  output logic [DAC_WORD_W-1:0]       dac_word,
  output logic                        start,
  output logic                        underrun,
  input  logic                        clr_underrun,
  output logic [$clog2(DEPTH):0]      fifo_level
);

  logic [15:0]             tcnt_q, tcnt_d;
  logic                    tick;
  dac_state_e              state_q;
  logic [15:0]             fcnt_q;
  logic                    start_q, underrun_q;
  logic [DAC_WORD_W-1:0]   dac_word_q;
  logic [DAC_SAMPLE_W-1:0] fifo_rdata;
  logic                    fifo_empty, pop;

  assign tick = enable && (tcnt_q == 16'(DIV-1));

  always_comb begin
    tcnt_d = '0;
    if (enable && !tick) tcnt_d = tcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= tcnt_d;
  end

  assign pop = (state_q == ST_IDLE) && tick && !fifo_empty;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DAC_SAMPLE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (sample_valid),
    .wdata_i (sample_in),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .ready_o (sample_ready),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fcnt_q     <= '0;
      start_q    <= 1'b1;
      dac_word_q <= to_dac_word(12'sd0);
      underrun_q <= 1'b0;
    end else begin
      // The set below is assigned later, so it overrides a coincident clear.
      if (clr_underrun) underrun_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q <= ST_FRAME;
            start_q <= 1'b0;
            fcnt_q  <= 16'(FRAME_LEN-1);
            if (!fifo_empty) dac_word_q <= to_dac_word(fifo_rdata);
            else             underrun_q <= 1'b1;
          end
        end
        ST_FRAME: begin
          if (fcnt_q == '0) begin
            state_q <= ST_GUARD;
            start_q <= 1'b1;
            fcnt_q  <= 16'(GUARD-1);
          end else begin
            fcnt_q <= fcnt_q - 1'b1;
          end
        end
        ST_GUARD: begin
          if (fcnt_q == '0) state_q <= ST_IDLE;
          else              fcnt_q  <= fcnt_q - 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          start_q <= 1'b1;
        end
      endcase
    end
  end

  assign start    = start_q;
  assign dac_word = dac_word_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_dac_frame_sched.sv
// Directed bench for dac_frame_sched: tick timing, formatting, FIFO limits, underrun and reset.
module tb_dac_frame_sched;

  logic        clk = 1'b0;
  logic        rst, enable, sample_valid, clr_underrun;
  logic [11:0] sample_in;
  logic        sample_ready, start, underrun;
  logic [15:0] dac_word;
  logic [2:0]  fifo_level;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int last_start = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dac_frame_sched dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .dac_word     (dac_word),
    .start        (start),
    .underrun     (underrun),
    .clr_underrun (clr_underrun),
    .fifo_level   (fifo_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (start !== 1'b0 && n < 3000);
    if (start !== 1'b0) begin
      err_cnt++;
      $display("FAIL frame_timeout: start=%b after %0d cycles, required 0", start, n);
    end
  endtask

  task automatic wait_frame_end(output int low, output bit stable);
    logic [15:0] w0;
    w0 = dac_word;
    low = 0;
    stable = 1'b1;
    while (start === 1'b0 && low < 3000) begin
      if (dac_word !== w0) stable = 1'b0;
      low++;
      step();
    end
    if (start !== 1'b1) begin
      err_cnt++;
      $display("FAIL frame_end_timeout: start=%b, required 1", start);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; sample_valid = 1'b0; clr_underrun = 1'b0; sample_in = '0;
    repeat (3) step();
    vec_cnt++; if (start !== 1'b1) begin err_cnt++; $display("FAIL rst_start: got %b, expected 1", start); end
    vec_cnt++; if (dac_word !== 16'h0800) begin err_cnt++; $display("FAIL rst_word: got %h, expected 0800", dac_word); end
    vec_cnt++; if (underrun !== 1'b0) begin err_cnt++; $display("FAIL rst_underrun: got %b, expected 0", underrun); end
    vec_cnt++; if (fifo_level !== 3'd0) begin err_cnt++; $display("FAIL rst_level: got %0d, expected 0", fifo_level); end
    vec_cnt++; if (sample_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_ready: got %b, expected 1", sample_ready); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_idle_underrun();
    int n, low;
    bit stable;
    enable = 1'b1;
    wait_frame(n);
    last_start = cyc;
    vec_cnt++; if (n !== 2272) begin err_cnt++; $display("FAIL first_tick: got %0d cycles, expected 2272", n); end
    vec_cnt++; if (dac_word !== 16'h0800) begin err_cnt++; $display("FAIL empty_word: got %h, expected 0800", dac_word); end
    vec_cnt++; if (underrun !== 1'b1) begin err_cnt++; $display("FAIL empty_underrun: got %b, expected 1", underrun); end
    wait_frame_end(low, stable);
    vec_cnt++; if (low !== 132) begin err_cnt++; $display("FAIL frame_len: got %0d, expected 132", low); end
    vec_cnt++; if (stable !== 1'b1) begin err_cnt++; $display("FAIL frame_stable0: got %b, expected 1", stable); end
  endtask

  task automatic test_sequence();
    logic [11:0] vals [4] = '{12'h800, 12'h000, 12'h7FF, 12'hFFF};
    logic [15:0] exps [4] = '{16'h0000, 16'h0800, 16'h0FFF, 16'h07FF};
    int n, low;
    bit stable;
    clr_underrun = 1'b1; step(); clr_underrun = 1'b0;
    vec_cnt++; if (underrun !== 1'b0) begin err_cnt++; $display("FAIL clr_alone: got %b, expected 0", underrun); end
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1; sample_in = vals[i]; step();
    end
    sample_valid = 1'b0;
    vec_cnt++; if (fifo_level !== 3'd4) begin err_cnt++; $display("FAIL seq_level: got %0d, expected 4", fifo_level); end
    for (int i = 0; i < 4; i++) begin
      wait_frame(n);
      vec_cnt++; if (cyc - last_start !== 2272) begin err_cnt++; $display("FAIL seq_period%0d: got %0d, expected 2272", i, cyc - last_start); end
      last_start = cyc;
      vec_cnt++; if (dac_word !== exps[i]) begin err_cnt++; $display("FAIL seq_word%0d: got %h, expected %h", i, dac_word, exps[i]); end
      wait_frame_end(low, stable);
      vec_cnt++; if (stable !== 1'b1 || low !== 132) begin err_cnt++; $display("FAIL seq_window%0d: stable=%b low=%0d, expected 1 and 132", i, stable, low); end
    end
    vec_cnt++; if (underrun !== 1'b0) begin err_cnt++; $display("FAIL seq_no_underrun: got %b, expected 0", underrun); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] vals [5] = '{12'h064, 12'hF9C, 12'h3E8, 12'hC18, 12'h007};
    logic [15:0] exps [5] = '{16'h0864, 16'h079C, 16'h0BE8, 16'h0418, 16'h0807};
    int n, low;
    bit stable;
    sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample_in = vals[i]; step();
    end
    vec_cnt++; if (fifo_level !== 3'd4) begin err_cnt++; $display("FAIL b2b_full_level: got %0d, expected 4", fifo_level); end
    vec_cnt++; if (sample_ready !== 1'b0) begin err_cnt++; $display("FAIL b2b_full_ready: got %b, expected 0", sample_ready); end
    repeat (10) step();
    vec_cnt++; if (fifo_level !== 3'd4) begin err_cnt++; $display("FAIL b2b_hold_level: got %0d, expected 4", fifo_level); end
    wait_frame(n);
    vec_cnt++; if (cyc - last_start !== 2272) begin err_cnt++; $display("FAIL b2b_period: got %0d, expected 2272", cyc - last_start); end
    last_start = cyc;
    vec_cnt++; if (dac_word !== exps[0]) begin err_cnt++; $display("FAIL b2b_word0: got %h, expected %h", dac_word, exps[0]); end
    vec_cnt++; if (fifo_level !== 3'd3 || sample_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_after_pop: level=%0d ready=%b, expected 3 and 1", fifo_level, sample_ready); end
    step();
    sample_valid = 1'b0;
    vec_cnt++; if (fifo_level !== 3'd4) begin err_cnt++; $display("FAIL b2b_fifth_push: got %0d, expected 4", fifo_level); end
    wait_frame_end(low, stable);
    for (int i = 1; i < 5; i++) begin
      wait_frame(n);
      last_start = cyc;
      vec_cnt++; if (dac_word !== exps[i]) begin err_cnt++; $display("FAIL b2b_word%0d: got %h, expected %h", i, dac_word, exps[i]); end
      wait_frame_end(low, stable);
    end
    vec_cnt++; if (fifo_level !== 3'd0) begin err_cnt++; $display("FAIL b2b_drained: got %0d, expected 0", fifo_level); end
  endtask

  task automatic test_push_on_tick();
    int n, low;
    bit stable;
    vec_cnt++; if (underrun !== 1'b0) begin err_cnt++; $display("FAIL pot_pre_underrun: got %b, expected 0", underrun); end
    while (cyc < last_start + 2271) step();
    sample_valid = 1'b1; sample_in = 12'hFFB;
    step();
    sample_valid = 1'b0;
    last_start = cyc;
    vec_cnt++; if (start !== 1'b0) begin err_cnt++; $display("FAIL pot_start: got %b, expected 0", start); end
    vec_cnt++; if (dac_word !== 16'h0807) begin err_cnt++; $display("FAIL pot_repeat: got %h, expected 0807", dac_word); end
    vec_cnt++; if (underrun !== 1'b1) begin err_cnt++; $display("FAIL pot_underrun: got %b, expected 1", underrun); end
    vec_cnt++; if (fifo_level !== 3'd1) begin err_cnt++; $display("FAIL pot_level: got %0d, expected 1", fifo_level); end
    wait_frame_end(low, stable);
    wait_frame(n);
    vec_cnt++; if (cyc - last_start !== 2272) begin err_cnt++; $display("FAIL pot_period: got %0d, expected 2272", cyc - last_start); end
    last_start = cyc;
    vec_cnt++; if (dac_word !== 16'h07FB) begin err_cnt++; $display("FAIL pot_next_word: got %h, expected 07FB", dac_word); end
    vec_cnt++; if (fifo_level !== 3'd0) begin err_cnt++; $display("FAIL pot_next_level: got %0d, expected 0", fifo_level); end
    wait_frame_end(low, stable);
  endtask

  task automatic test_underrun_clear();
    clr_underrun = 1'b1; step(); clr_underrun = 1'b0;
    vec_cnt++; if (underrun !== 1'b0) begin err_cnt++; $display("FAIL uc_clear: got %b, expected 0", underrun); end
    while (cyc < last_start + 2271) step();
    clr_underrun = 1'b1;
    step();
    clr_underrun = 1'b0;
    last_start = cyc;
    vec_cnt++; if (start !== 1'b0) begin err_cnt++; $display("FAIL uc_start: got %b, expected 0", start); end
    vec_cnt++; if (underrun !== 1'b1) begin err_cnt++; $display("FAIL uc_set_wins: got %b, expected 1", underrun); end
    vec_cnt++; if (dac_word !== 16'h07FB) begin err_cnt++; $display("FAIL uc_repeat: got %h, expected 07FB", dac_word); end
  endtask

  task automatic test_reset_mid_frame();
    int n, low;
    bit stable;
    sample_valid = 1'b1; sample_in = 12'h123; step(); sample_valid = 1'b0;
    vec_cnt++; if (fifo_level !== 3'd1) begin err_cnt++; $display("FAIL rmf_level_pre: got %0d, expected 1", fifo_level); end
    repeat (48) step();
    vec_cnt++; if (start !== 1'b0) begin err_cnt++; $display("FAIL rmf_in_frame: got %b, expected 0", start); end
    rst = 1'b1;
    #1;
    vec_cnt++; if (start !== 1'b1) begin err_cnt++; $display("FAIL rmf_start: got %b, expected 1", start); end
    vec_cnt++; if (dac_word !== 16'h0800) begin err_cnt++; $display("FAIL rmf_word: got %h, expected 0800", dac_word); end
    vec_cnt++; if (fifo_level !== 3'd0) begin err_cnt++; $display("FAIL rmf_level: got %0d, expected 0", fifo_level); end
    vec_cnt++; if (underrun !== 1'b0 || sample_ready !== 1'b1) begin err_cnt++; $display("FAIL rmf_flags: underrun=%b ready=%b, expected 0 and 1", underrun, sample_ready); end
    step();
    rst = 1'b0;
    wait_frame(n);
    vec_cnt++; if (n !== 2272) begin err_cnt++; $display("FAIL rmf_first_tick: got %0d cycles, expected 2272", n); end
    vec_cnt++; if (dac_word !== 16'h0800 || underrun !== 1'b1) begin err_cnt++; $display("FAIL rmf_discard: word=%h underrun=%b, expected 0800 and 1", dac_word, underrun); end
    wait_frame_end(low, stable);
  endtask

  initial begin
    test_reset();
    test_idle_underrun();
    test_sequence();
    test_back_to_back();
    test_push_on_tick();
    test_underrun_clear();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
